// File: rtl/sdram_init_monitor_pkg.sv
// rtl/sdram_init_monitor_pkg.sv - shared command and error encodings for the SDRAM init monitor
package sdram_init_monitor_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_PWR    = 3'd1;
  localparam logic [2:0] ERR_SEQ    = 3'd2;
  localparam logic [2:0] ERR_TIMING = 3'd3;
  localparam logic [2:0] ERR_REFCNT = 3'd4;
  localparam logic [2:0] ERR_A10    = 3'd5;

  typedef enum logic [2:0] {C_IDLE, C_PRE, C_REF, C_LMR, C_OTHER} cmd_e;

  function automatic cmd_e decode_cmd(input logic [3:0] c);
    cmd_e r;
    if (c[3]) r = C_IDLE;
    else begin
      case (c)
        CMD_NOP: r = C_IDLE;
        CMD_PRE: r = C_PRE;
        CMD_REF: r = C_REF;
        CMD_LMR: r = C_LMR;
        default: r = C_OTHER;
      endcase
    end
    return r;
  endfunction

  function automatic int gap_width(input int t_powerup);
    int w;
    w = $clog2(t_powerup + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/sdram_init_monitor_if.sv
// rtl/sdram_init_monitor_if.sv - controller-to-SDRAM command bus as seen by the monitor
interface sdram_init_monitor_if #(parameter int ASIZE = 12);
  logic [3:0]       command;
  logic [ASIZE-1:0] saddr;

  modport master (output command, output saddr);
  modport slave  (input command, input saddr);
endinterface

// File: rtl/sdram_init_monitor_gap_cnt.sv
// rtl/sdram_init_monitor_gap_cnt.sv - saturating gap counter, cleared to 1 after each command
module sdram_gap_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (clr) count <= WIDTH'(1);
    else if (count != '1) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// rtl/sdram_init_monitor.sv - checks order and spacing of the SDRAM power-up init sequence
module sdram_init_monitor
  import sdram_init_monitor_pkg::*;
#(
  parameter int ASIZE     = 12,
  parameter int T_POWERUP = 20000,
  parameter int T_RP      = 2,
  parameter int T_RC      = 7,
  parameter int T_MRD     = 2,
  parameter int REF_COUNT = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  sdram_init_monitor_if.slave  bus,
  output logic                 init_ok,
  output logic                 init_err,
  output logic [2:0]           err_code,
  output logic [ASIZE-1:0]     mode_reg,
  output logic [2:0]           cas_lat,
  output logic [2:0]           burst_len,
  output logic [7:0]           ref_cnt
);

  localparam int GW = gap_width(T_POWERUP);
  localparam logic [GW-1:0] T_PWR_G = GW'(T_POWERUP);
  localparam logic [GW-1:0] T_RP_G  = GW'(T_RP);
  localparam logic [GW-1:0] T_RC_G  = GW'(T_RC);
  localparam logic [GW-1:0] T_MRD_G = GW'(T_MRD);
  localparam logic [GW:0]   T_MRD_X = (GW+1)'(T_MRD);
  localparam logic [7:0]    REF_MIN = 8'(REF_COUNT);

  typedef enum logic [2:0] {S_PWR, S_TRP, S_REF, S_MRD, S_DONE, S_ERR} state_t;

  state_t          state;
  cmd_e            cmd;
  logic [GW-1:0]   gap;
  logic [GW:0]     gap_inc;
  logic [2:0]      viol;

  assign cmd     = decode_cmd(bus.command);
  assign gap_inc = {1'b0, gap} + {{GW{1'b0}}, 1'b1};

  sdram_gap_cnt #(.WIDTH(GW)) u_gap (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cmd != C_IDLE),
    .count (gap)
  );

  // Timing violations outrank the refresh-count check on LMR.
  always_comb begin
    viol = ERR_NONE;
    case (state)
      S_PWR: begin
        if (cmd == C_PRE) begin
          if (gap < T_PWR_G) viol = ERR_PWR;
          else if (!bus.saddr[10]) viol = ERR_A10;
        end else if (cmd != C_IDLE) viol = ERR_SEQ;
      end
      S_TRP: begin
        if (cmd == C_REF) begin
          if (gap < T_RP_G) viol = ERR_TIMING;
        end else if (cmd != C_IDLE) viol = ERR_SEQ;
      end
      S_REF: begin
        if (cmd == C_REF || cmd == C_LMR) begin
          if (gap < T_RC_G) viol = ERR_TIMING;
          else if (cmd == C_LMR && ref_cnt < REF_MIN) viol = ERR_REFCNT;
        end else if (cmd != C_IDLE) viol = ERR_SEQ;
      end
      S_MRD: begin
        if (cmd != C_IDLE && gap < T_MRD_G) viol = ERR_TIMING;
      end
      default: viol = ERR_NONE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_PWR;
      init_ok  <= 1'b0;
      init_err <= 1'b0;
      err_code <= ERR_NONE;
      mode_reg <= '0;
      ref_cnt  <= '0;
    end else if (viol != ERR_NONE) begin
      state    <= S_ERR;
      init_err <= 1'b1;
      err_code <= viol;
    end else begin
      case (state)
        S_PWR: if (cmd == C_PRE) state <= S_TRP;
        S_TRP: begin
          if (cmd == C_REF) begin
            state   <= S_REF;
            ref_cnt <= 8'd1;
          end
        end
        S_REF: begin
          if (cmd == C_REF) begin
            if (ref_cnt != 8'hFF) ref_cnt <= ref_cnt + 8'd1;
          end else if (cmd == C_LMR) begin
            mode_reg <= bus.saddr;
            state    <= S_MRD;
          end
        end
        // Flag one edge early so init_ok is visible in the cycle where G reaches T_MRD.
        S_MRD: begin
          if (gap_inc >= T_MRD_X) begin
            init_ok <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign cas_lat   = mode_reg[6:4];
  assign burst_len = mode_reg[2:0];

endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
- Responder-side checker for the SDRAM power-up initialisation sequence.
- Sits on the controller-to-SDRAM command bus: {CS_N,RAS_N,CAS_N,WE_N} plus address.
- Decodes every command and enforces order and minimum spacing: power-up wait, PRECHARGE ALL, N×AUTO REFRESH, LOAD MODE REGISTER.
- Reports pass/fail and the captured mode register. Synthesisable, usable on-chip or in benches alongside the sdr model.

Parameters:
ASIZE, 12, SDRAM address width (same as `ASIZE)
T_POWERUP, 20000, min cycles from reset release to PRECHARGE (200 us @ 100 MHz)
T_RP, 2, min cycles PRECHARGE -> first AUTO REFRESH
T_RC, 7, min cycles AUTO REFRESH -> next AUTO REFRESH or LOAD MODE
T_MRD, 2, min cycles LOAD MODE -> init_ok
REF_COUNT, 8, required number of AUTO REFRESH commands

Ports:
CLK  in  1  system clock, 100 MHz
RST  in  1  synchronous active-high reset
command  in  4  {CS_N,RAS_N,CAS_N,WE_N}
saddr  in  ASIZE  SDRAM address bus
init_ok  out  1  sticky: sequence completed legally
init_err  out  1  sticky: first violation detected
err_code  out  3  code of first violation
mode_reg  out  ASIZE  saddr captured at LOAD MODE
cas_lat  out  3  mode_reg[6:4]
burst_len  out  3  mode_reg[2:0]
ref_cnt  out  8  AUTO REFRESH commands seen

Behaviour:
- Decode: CS_N=1 INHIBIT; 0111 NOP; 0010 PRE; 0001 REF; 0000 LMR; any other value is OTHER. INHIBIT and NOP are idle and always legal.
- Reset (RST=1 at a CLK edge):
  - All outputs 0; state S_PWR; gap counter G=0.
  - Mid-sequence reset abandons progress and restarts the power-up wait.
- Gap counter G (saturating at all-ones, width clog2(T_POWERUP+1), minimum 4):
  - G=0 in the first cycle after reset release; +1 every cycle.
  - Cleared to 1 in the cycle after any accepted non-idle command.
  - Spacing check compares G in the command cycle against the required minimum.
- States and transitions:
  - S_PWR:
    - PRE with G>=T_POWERUP and saddr[10]=1 -> S_TRP.
    - PRE with G<T_POWERUP -> err 1 (PWR).
    - PRE with saddr[10]=0 -> err 5 (A10). If both conditions fail, report err 1.
    - REF/LMR/OTHER -> err 2 (SEQ).
  - S_TRP:
    - REF with G>=T_RP -> S_REF, ref_cnt=1.
    - REF with G<T_RP -> err 3 (TIMING).
    - PRE/LMR/OTHER -> err 2.
  - S_REF:
    - REF with G>=T_RC -> ref_cnt+1, saturating at 255.
    - LMR with G>=T_RC and ref_cnt>=REF_COUNT -> capture mode_reg=saddr, go to S_MRD.
    - LMR with ref_cnt<REF_COUNT -> err 4 (REFCNT).
    - REF/LMR with G<T_RC -> err 3; timing takes priority over REFCNT.
    - PRE/OTHER -> err 2.
  - S_MRD:
    - Idle cycles until G==T_MRD, then init_ok=1 in that cycle and go to S_DONE.
    - Any non-idle command while G<T_MRD -> err 3.
  - S_DONE: terminal; commands ignored; outputs hold until RST.
  - S_ERR:
    - Entered on any error; init_err=1 and err_code latched in the error cycle (registered, visible the next cycle).
    - Terminal until RST; later violations do not overwrite err_code.
- init_ok and init_err are never both 1.
- mode_reg, cas_lat and burst_len stay 0 until the LMR capture.

Decomposition:
- Shared params.h additions: command encodings (CMD_NOP, CMD_PRE, CMD_REF, CMD_LMR), err_code constants (ERR_PWR=1, ERR_SEQ=2, ERR_TIMING=3, ERR_REFCNT=4, ERR_A10=5). State encoding stays local.
- One sub-module, sdram_gap_cnt: saturating counter with clear-to-1 and sync reset.

Test Plan (T_POWERUP=100, T_RP=2, T_RC=7, T_MRD=2, REF_COUNT=8):
- Legal sequence: PRE(A10=1) at G=100, REF×8 spaced 7, LMR saddr=0x032 after 7, NOPs -> init_ok=1 exactly 2 cycles after LMR; cas_lat=3, burst_len=2, ref_cnt=8, init_err=0.
- PRE at G=99 -> init_err=1, err_code=1, init_ok stays 0 for the remaining stimulus.
- Second REF 6 cycles after first -> err_code=3; a later LMR leaves err_code at 3.
- LMR after only 7 REFs, spacing legal -> err_code=4; mode_reg stays 0.
- PRE with saddr[10]=0 at G=150 -> err_code=5; READ (0101) in S_TRP on a fresh run -> err_code=2.
- RST pulsed after 4th REF, then full legal sequence -> all outputs cleared during reset; init_ok=1 on completion with ref_cnt=8.
